// File: rtl/cpu_dbg_pkg.sv
// Shared definitions for the CPU run-control / state-dump slice.
// Holds the controller state encoding, the beat-kind codes, the debug-port
// widths and a saturating increment for the run-cycle counter.
package cpu_dbg_pkg;

    typedef enum logic [2:0] {
        RUN     = 3'd0,
        FREEZE  = 3'd1,
        DUMP_RF = 3'd2,
        DUMP_DM = 3'd3,
        DRAIN   = 3'd4,
        DONE    = 3'd5
    } dbg_state_e;

    localparam logic DUMP_KIND_REG = 1'b0;
    localparam logic DUMP_KIND_MEM = 1'b1;

    localparam int PC_W       = 32;
    localparam int RF_ADDR_W  = 5;
    localparam int DUMP_IDX_W = 8;
    localparam int CYCLE_W    = 16;
    localparam int REP_W      = 8;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CYCLE_W-1:0] sat_inc_cycles(input logic [CYCLE_W-1:0] value);
        if (value == {CYCLE_W{1'b1}}) begin
            return value;
        end else begin
            return value + {{(CYCLE_W-1){1'b0}}, 1'b1};
        end
    endfunction

endpackage

// File: rtl/dump_beat_reg.sv
// Valid/ready holding register for one dump beat.
// Ports:
//   clk_i, rst_i    clock, synchronous active-high reset
//   load_req_i      owner wants to present a new beat this cycle
//   kind_i/index_i/data_i  candidate beat contents
//   ready_i         sink ready
//   load_en_o       beat is captured at the next edge (slot empty or draining)
//   valid_o/kind_o/index_o/data_o  registered beat presented to the sink
// With no load request pending, a transferred beat simply empties the slot,
// which is how the final beat drains.
module dump_beat_reg
    import cpu_dbg_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int IDX_W  = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_req_i,
    input  logic              kind_i,
    input  logic [IDX_W-1:0]  index_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              ready_i,
    output logic              load_en_o,
    output logic              valid_o,
    output logic              kind_o,
    output logic [IDX_W-1:0]  index_o,
    output logic [DATA_W-1:0] data_o
);

    logic              valid_r;
    logic              kind_r;
    logic [IDX_W-1:0]  index_r;
    logic [DATA_W-1:0] data_r;

    // Slot can take a new beat when empty or when the current one leaves now.
    always_comb begin
        load_en_o = load_req_i && (!valid_r || ready_i);
    end

    // Beat storage: load, drain, or hold stable under back-pressure.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_r <= 1'b0;
            kind_r  <= DUMP_KIND_REG;
            index_r <= {IDX_W{1'b0}};
            data_r  <= {DATA_W{1'b0}};
        end else if (load_en_o) begin
            valid_r <= 1'b1;
            kind_r  <= kind_i;
            index_r <= index_i;
            data_r  <= data_i;
        end else if (valid_r && ready_i) begin
            valid_r <= 1'b0;
        end else begin
            valid_r <= valid_r;
        end
    end

    assign valid_o = valid_r;
    assign kind_o  = kind_r;
    assign index_o = index_r;
    assign data_o  = data_r;

endmodule

// File: rtl/cpu_state_dumper.sv
// Run-control and end-of-run state dump for the single-cycle CPU.
// Counts RUN cycles, detects a halt (PC unchanged for HALT_REPEAT cycles) or a
// timeout, freezes the CPU, then streams every register-file entry followed by
// every data-memory word over a valid/ready interface.
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   cpu_pc_i                current CPU program counter
//   cpu_stall_o             freeze request, sticky until reset
//   rf_raddr_o/rf_rdata_i   register-file debug read port (combinational)
//   dm_raddr_o/dm_rdata_i   data-memory debug read port (combinational)
//   dump_valid_o/dump_ready_i  beat handshake
//   dump_kind_o/dump_index_o/dump_data_o  beat contents
//   halted_o                1 = ended by halt detect, 0 = ended by timeout
//   done_o                  dump complete, sticky
//   cycles_o                RUN cycles, saturating, frozen on leaving RUN
module cpu_state_dumper
    import cpu_dbg_pkg::*;
#(
    parameter int END_COUNT   = 600,
    parameter int HALT_REPEAT = 3,
    parameter int REG_NUM     = 32,
    parameter int MEM_WORDS   = 12,
    parameter int DATA_W      = 32
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [31:0]                  cpu_pc_i,
    output logic                         cpu_stall_o,
    output logic [4:0]                   rf_raddr_o,
    input  logic [DATA_W-1:0]            rf_rdata_i,
    output logic [$clog2(MEM_WORDS)-1:0] dm_raddr_o,
    input  logic [DATA_W-1:0]            dm_rdata_i,
    output logic                         dump_valid_o,
    input  logic                         dump_ready_i,
    output logic                         dump_kind_o,
    output logic [7:0]                   dump_index_o,
    output logic [DATA_W-1:0]            dump_data_o,
    output logic                         halted_o,
    output logic                         done_o,
    output logic [15:0]                  cycles_o
);

    localparam int DM_ADDR_W = $clog2(MEM_WORDS);

    dbg_state_e              state_r;
    dbg_state_e              state_s;
    logic [CYCLE_W-1:0]      cyc_r;
    logic [REP_W-1:0]        rep_r;
    logic [PC_W-1:0]         prev_pc_r;
    logic                    stall_r;
    logic                    halted_r;
    logic                    done_r;
    logic [DUMP_IDX_W-1:0]   idx_r;

    logic                    pc_eq_s;
    logic [REP_W-1:0]        rep_inc_s;
    logic                    halt_hit_s;
    logic                    timeout_hit_s;
    logic                    last_rf_s;
    logic                    last_dm_s;
    logic                    load_req_s;
    logic                    load_en_s;
    logic                    beat_kind_s;
    logic [DATA_W-1:0]       beat_data_s;
    logic                    beat_valid_s;

    // Halt/timeout detection and end-of-table flags.
    // Halt fires on the cycle whose equal PC brings the repeat count to HALT_REPEAT-1.
    always_comb begin
        pc_eq_s       = (cpu_pc_i == prev_pc_r);
        rep_inc_s     = rep_r + {{(REP_W-1){1'b0}}, 1'b1};
        halt_hit_s    = pc_eq_s && (rep_inc_s == REP_W'(HALT_REPEAT - 1));
        timeout_hit_s = (cyc_r == CYCLE_W'(END_COUNT - 1));
        last_rf_s     = (idx_r == DUMP_IDX_W'(REG_NUM - 1));
        last_dm_s     = (idx_r == DUMP_IDX_W'(MEM_WORDS - 1));
    end

    // Controller state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r <= RUN;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            RUN: begin
                if (halt_hit_s || timeout_hit_s) begin
                    state_s = FREEZE;
                end else begin
                    state_s = RUN;
                end
            end
            FREEZE: begin
                state_s = DUMP_RF;
            end
            DUMP_RF: begin
                if (load_en_s && last_rf_s) begin
                    state_s = DUMP_DM;
                end else begin
                    state_s = DUMP_RF;
                end
            end
            DUMP_DM: begin
                if (load_en_s && last_dm_s) begin
                    state_s = DRAIN;
                end else begin
                    state_s = DUMP_DM;
                end
            end
            DRAIN: begin
                if (!beat_valid_s) begin
                    state_s = DONE;
                end else begin
                    state_s = DRAIN;
                end
            end
            DONE: begin
                state_s = DONE;
            end
            default: begin
                state_s = RUN;
            end
        endcase
    end

    // RUN bookkeeping: cycle count, PC repeat tracking, stall and halt cause.
    // The cycle counter does not step on the exit edge so it freezes at the exit value.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cyc_r     <= {CYCLE_W{1'b0}};
            rep_r     <= {REP_W{1'b0}};
            prev_pc_r <= {PC_W{1'b0}};
            stall_r   <= 1'b0;
            halted_r  <= 1'b0;
        end else begin
            case (state_r)
                RUN: begin
                    prev_pc_r <= cpu_pc_i;
                    rep_r     <= pc_eq_s ? rep_inc_s : {REP_W{1'b0}};
                    if (halt_hit_s || timeout_hit_s) begin
                        stall_r  <= 1'b1;
                        halted_r <= halt_hit_s;
                    end else begin
                        cyc_r <= sat_inc_cycles(cyc_r);
                    end
                end
                default: begin
                    cyc_r <= cyc_r;
                end
            endcase
        end
    end

    // Dump index: cleared in FREEZE, steps on each captured beat, rewinds between tables.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            idx_r <= {DUMP_IDX_W{1'b0}};
        end else begin
            case (state_r)
                FREEZE: begin
                    idx_r <= {DUMP_IDX_W{1'b0}};
                end
                DUMP_RF: begin
                    if (load_en_s) begin
                        idx_r <= last_rf_s ? {DUMP_IDX_W{1'b0}} : idx_r + 8'd1;
                    end
                end
                DUMP_DM: begin
                    if (load_en_s && !last_dm_s) begin
                        idx_r <= idx_r + 8'd1;
                    end
                end
                default: begin
                    idx_r <= idx_r;
                end
            endcase
        end
    end

    // Sticky completion flag, raised on the DRAIN-to-DONE edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            done_r <= 1'b0;
        end else if ((state_r == DRAIN) && (state_s == DONE)) begin
            done_r <= 1'b1;
        end else begin
            done_r <= done_r;
        end
    end

    // Beat source selection for the holding register.
    always_comb begin
        load_req_s  = 1'b0;
        beat_kind_s = DUMP_KIND_REG;
        beat_data_s = rf_rdata_i;
        case (state_r)
            DUMP_RF: begin
                load_req_s  = 1'b1;
                beat_kind_s = DUMP_KIND_REG;
                beat_data_s = rf_rdata_i;
            end
            DUMP_DM: begin
                load_req_s  = 1'b1;
                beat_kind_s = DUMP_KIND_MEM;
                beat_data_s = dm_rdata_i;
            end
            default: begin
                load_req_s = 1'b0;
            end
        endcase
    end

    dump_beat_reg #(
        .DATA_W (DATA_W),
        .IDX_W  (DUMP_IDX_W)
    ) u_beat (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_req_i (load_req_s),
        .kind_i     (beat_kind_s),
        .index_i    (idx_r),
        .data_i     (beat_data_s),
        .ready_i    (dump_ready_i),
        .load_en_o  (load_en_s),
        .valid_o    (beat_valid_s),
        .kind_o     (dump_kind_o),
        .index_o    (dump_index_o),
        .data_o     (dump_data_o)
    );

    assign dump_valid_o = beat_valid_s;
    assign rf_raddr_o   = idx_r[RF_ADDR_W-1:0];
    assign dm_raddr_o   = idx_r[DM_ADDR_W-1:0];
    assign cpu_stall_o  = stall_r;
    assign halted_o     = halted_r;
    assign done_o       = done_r;
    assign cycles_o     = cyc_r;

endmodule

// File: tb/tb_cpu_state_dumper.sv
module tb_cpu_state_dumper;

    localparam int END_COUNT   = 600;
    localparam int HALT_REPEAT = 3;
    localparam int REG_NUM     = 32;
    localparam int MEM_WORDS   = 12;
    localparam int DATA_W      = 32;
    localparam int DM_W        = $clog2(MEM_WORDS);
    localparam int TOTAL_BEATS = REG_NUM + MEM_WORDS;

    logic              clk_i;
    logic              rst_i;
    logic [31:0]       cpu_pc_i;
    logic              cpu_stall_o;
    logic [4:0]        rf_raddr_o;
    logic [DATA_W-1:0] rf_rdata_i;
    logic [DM_W-1:0]   dm_raddr_o;
    logic [DATA_W-1:0] dm_rdata_i;
    logic              dump_valid_o;
    logic              dump_ready_i;
    logic              dump_kind_o;
    logic [7:0]        dump_index_o;
    logic [DATA_W-1:0] dump_data_o;
    logic              halted_o;
    logic              done_o;
    logic [15:0]       cycles_o;

    cpu_state_dumper #(
        .END_COUNT(END_COUNT), .HALT_REPEAT(HALT_REPEAT),
        .REG_NUM(REG_NUM), .MEM_WORDS(MEM_WORDS), .DATA_W(DATA_W)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .cpu_pc_i(cpu_pc_i), .cpu_stall_o(cpu_stall_o),
        .rf_raddr_o(rf_raddr_o), .rf_rdata_i(rf_rdata_i),
        .dm_raddr_o(dm_raddr_o), .dm_rdata_i(dm_rdata_i),
        .dump_valid_o(dump_valid_o), .dump_ready_i(dump_ready_i),
        .dump_kind_o(dump_kind_o), .dump_index_o(dump_index_o), .dump_data_o(dump_data_o),
        .halted_o(halted_o), .done_o(done_o), .cycles_o(cycles_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Behavioural CPU-side storage seen through the debug read ports.
    logic [DATA_W-1:0] rf_mem [0:REG_NUM-1];
    logic [DATA_W-1:0] dm_mem [0:MEM_WORDS-1];
    logic [31:0]       pcs    [0:END_COUNT-1];

    assign rf_rdata_i = rf_mem[rf_raddr_o];
    assign dm_rdata_i = (int'(dm_raddr_o) < MEM_WORDS) ? dm_mem[dm_raddr_o] : 32'hDEAD_BEEF;

    typedef struct packed {
        logic        kind;
        logic [7:0]  idx;
        logic [31:0] data;
    } beat_t;

    beat_t exp_q[$];
    int    tests = 0;
    int    fails = 0;
    int    beats_seen = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: pops the scoreboard on each transfer and checks hold stability.
    initial begin
        beat_t cur;
        beat_t prev;
        beat_t e;
        logic  hold_pending;
        hold_pending = 1'b0;
        prev = '0;
        forever begin
            @(negedge clk_i);
            cur = '{kind: dump_kind_o, idx: dump_index_o, data: dump_data_o};
            if (rst_i) begin
                hold_pending = 1'b0;
            end else begin
                if (hold_pending) begin
                    check("hold_valid", {63'd0, dump_valid_o}, 64'd1);
                    check("hold_beat", {23'd0, cur}, {23'd0, prev});
                end
                if (dump_valid_o && dump_ready_i) begin
                    beats_seen++;
                    if (exp_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL beat_extra: got beat %0h, expected none", cur);
                    end else begin
                        e = exp_q.pop_front();
                        check("beat", {23'd0, cur}, {23'd0, e});
                    end
                end
                hold_pending = dump_valid_o && !dump_ready_i;
                prev = cur;
            end
        end
    end

    function automatic logic ready_val(input int mode, input int k);
        case (mode)
            0:       return 1'b1;
            1:       return ((k % 4) == 0) || ((k % 4) == 3);
            default: return ($urandom_range(0, 3) != 0);
        endcase
    endfunction

    // pc_mode: 0 = step by 4 then stick at stuck_k, 1 = step forever, 2 = random with repeats
    task automatic run_scenario(input int pc_mode, input logic [31:0] base, input int stuck_k,
                                input int ready_mode, input int data_mode, input int reset_at_beat);
        int          fk;
        logic        h;
        int          run_len;
        logic [31:0] prevpc;
        logic [31:0] tmp;
        int          k;
        int          f;
        int          limit;
        logic        finished;

        for (int i = 0; i < REG_NUM; i++) rf_mem[i] = (data_mode == 0) ? 32'(i * 3) : $urandom;
        for (int j = 0; j < MEM_WORDS; j++) dm_mem[j] = (data_mode == 0) ? 32'(100 + j) : $urandom;

        for (int i = 0; i < END_COUNT; i++) begin
            case (pc_mode)
                0: pcs[i] = base + 32'(4 * ((i < stuck_k) ? i : stuck_k));
                1: pcs[i] = base + 32'(4 * i);
                default: begin
                    tmp = $urandom;
                    if (i > 0 && $urandom_range(0, 2) == 0) pcs[i] = pcs[i-1];
                    else pcs[i] = {tmp[31:2], 2'b00};
                end
            endcase
        end

        // Reference: first cycle where the PC has held for HALT_REPEAT cycles
        // (the pre-run PC is 0), otherwise the timeout cycle.
        prevpc = 32'd0;
        run_len = 1;
        fk = END_COUNT - 1;
        h = 1'b0;
        for (int i = 0; i < END_COUNT; i++) begin
            if (pcs[i] == prevpc) run_len++;
            else run_len = 1;
            prevpc = pcs[i];
            if (run_len >= HALT_REPEAT) begin
                fk = i;
                h = 1'b1;
                break;
            end
        end

        exp_q.delete();
        for (int i = 0; i < REG_NUM; i++) exp_q.push_back('{kind: 1'b0, idx: 8'(i), data: rf_mem[i]});
        for (int j = 0; j < MEM_WORDS; j++) exp_q.push_back('{kind: 1'b1, idx: 8'(j), data: dm_mem[j]});
        beats_seen = 0;

        rst_i = 1'b1;
        cpu_pc_i = 32'd0;
        dump_ready_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0;

        f = fk + 1;
        limit = f + 400;
        finished = 1'b0;
        k = 0;
        while (!finished) begin
            cpu_pc_i = pcs[(k < END_COUNT) ? k : END_COUNT - 1];
            dump_ready_i = ready_val(ready_mode, k);
            @(negedge clk_i);
            #1;
            if (k == 0) begin
                check("reset_ctrl", {26'd0, cpu_stall_o, rf_raddr_o, dm_raddr_o, dump_valid_o, dump_kind_o,
                                     dump_index_o, halted_o, done_o, cycles_o}, 64'd0);
                check("reset_data", {32'd0, dump_data_o}, 64'd0);
            end
            if (k == fk) check("stall_before_freeze", {63'd0, cpu_stall_o}, 64'd0);
            if (k == f) begin
                check("stall_at_freeze", {63'd0, cpu_stall_o}, 64'd1);
                check("halted", {63'd0, halted_o}, {63'd0, h});
                check("cycles", {48'd0, cycles_o}, 64'(fk));
            end
            if (reset_at_beat >= 0 && beats_seen == reset_at_beat && k > f) begin
                @(posedge clk_i);
                #1;
                rst_i = 1'b1;
                @(posedge clk_i);
                @(negedge clk_i);
                #1;
                check("rst_valid", {63'd0, dump_valid_o}, 64'd0);
                check("rst_stall", {63'd0, cpu_stall_o}, 64'd0);
                check("rst_cycles", {48'd0, cycles_o}, 64'd0);
                check("rst_done_halted", {62'd0, done_o, halted_o}, 64'd0);
                exp_q.delete();
                finished = 1'b1;
            end else if (ready_mode == 0 && k == f + 46) begin
                check("done_early", {63'd0, done_o}, 64'd0);
            end else if (ready_mode == 0 && k == f + 47) begin
                check("done_latency", {63'd0, done_o}, 64'd1);
                finished = 1'b1;
            end else if (ready_mode != 0 && k > f && done_o) begin
                finished = 1'b1;
            end else if (k >= limit) begin
                tests++;
                fails++;
                $display("FAIL timeout: got no done_o after %0d cycles, expected done", k);
                finished = 1'b1;
            end
            if (!finished) begin
                @(posedge clk_i);
                #1;
                k++;
            end
        end

        if (reset_at_beat < 0) begin
            check("beat_count", 64'(beats_seen), 64'(TOTAL_BEATS));
            check("queue_empty", 64'(exp_q.size()), 64'd0);
            check("done_final", {63'd0, done_o}, 64'd1);
            check("stall_final", {63'd0, cpu_stall_o}, 64'd1);
        end
    endtask

    initial begin
        logic [31:0] r;
        rst_i = 1'b1;
        cpu_pc_i = 32'd0;
        dump_ready_i = 1'b0;
        // PC 0,4,8,8,8 halt; fixed tables; ready high
        run_scenario(0, 32'd0, 2, 0, 0, -1);
        // Runaway PC reaches the timeout
        run_scenario(1, 32'h0000_0400, 0, 0, 1, -1);
        // Halt and timeout coincide; ready 1,0,0,1 pattern
        run_scenario(0, 32'h0000_0100, END_COUNT - 3, 1, 0, -1);
        // Random halt point and random back-pressure
        r = $urandom;
        run_scenario(0, {r[31:2], 2'b00}, $urandom_range(5, 50), 2, 1, -1);
        // Random PC stream with repeats
        run_scenario(2, 32'd0, 0, 2, 1, -1);
        run_scenario(2, 32'd0, 0, 0, 1, -1);
        // Reset in the middle of the register dump
        run_scenario(0, 32'd0, 2, 0, 0, 10);
        // Recovery after mid-dump reset
        run_scenario(0, 32'h0000_2000, 20, 1, 1, -1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cpu_state_dumper.md
Name: cpu_state_dumper

Overview:
- Run-control and end-of-run state dump unit that sits downstream of the single-cycle CPU (Simple_Single_CPU).
- Counts CPU cycles and detects a halt (PC stuck) or a timeout.
- On halt or timeout it freezes the CPU, then reads the register file and data memory word by word through spare read ports.
- Each word is streamed out on a valid/ready interface to a UART or trace sink, replacing bench-side hierarchical peeking.

Parameters:
- END_COUNT, 600: timeout in cycles after reset release.
- HALT_REPEAT, 3: number of consecutive cycles with unchanged PC that counts as a halt (e.g. jump-to-self).
- REG_NUM, 32: number of register-file entries dumped.
- MEM_WORDS, 12: number of data-memory words dumped (word indices 0..MEM_WORDS-1).
- DATA_W, 32: data width.

Ports:
- clk_i  in  1  clock. One clock domain only.
- rst_i  in  1  reset. Reset is synchronous and active-high.
- cpu_pc_i  in  32  current CPU program counter.
- cpu_stall_o  out  1  freeze request to the CPU. While high, the CPU holds its PC and suppresses RF/DM writes.
- rf_raddr_o  out  5  register-file debug read address.
- rf_rdata_i  in  DATA_W  register-file debug read data. Combinational, same cycle as the address.
- dm_raddr_o  out  $clog2(MEM_WORDS)  data-memory debug word index.
- dm_rdata_i  in  DATA_W  data-memory debug read data. Combinational, same cycle as the index.
- dump_valid_o  out  1  dump beat valid.
- dump_ready_i  in  1  sink ready.
- dump_kind_o  out  1  0 = register, 1 = memory word.
- dump_index_o  out  8  register number or memory word index.
- dump_data_o  out  DATA_W  dumped value.
- halted_o  out  1  1 if the run ended by halt detect, 0 if it ended by timeout. Valid once cpu_stall_o is high.
- done_o  out  1  dump complete, sticky.
- cycles_o  out  16  cycles spent in RUN. Frozen on leaving RUN.

Behaviour:
- Reset values: all outputs 0. State RUN. Cycle counter 0. PC-repeat counter 0. Previous-PC register 0.
- Reset mid-operation returns to RUN from any state on the next edge and drops dump_valid_o with no handshake.

RUN:
- cycles_o increments every cycle. It saturates at 16'hFFFF.
- If cpu_pc_i equals the previous PC, the repeat counter increments; otherwise it clears.
- Transition to FREEZE when the repeat counter reaches HALT_REPEAT-1 with an equal PC. Set halted_o = 1.
- Otherwise transition to FREEZE when cycles_o == END_COUNT-1. Set halted_o = 0.
- If both conditions hit in the same cycle, halted_o = 1 (halt wins).

FREEZE:
- cpu_stall_o is registered and goes high on entry. It stays high until reset.
- Exactly one cycle, so the final writeback settles.
- Then go to DUMP_RF with index = 0.

DUMP_RF:
- rf_raddr_o = index.
- When dump_valid_o is 0 or (dump_valid_o && dump_ready_i), load dump_data_o = rf_rdata_i, dump_kind_o = 0, dump_index_o = index. Assert dump_valid_o and increment index.
- While dump_valid_o && !dump_ready_i, hold dump_data_o, dump_kind_o and dump_index_o stable. Do not advance.
- After loading index REG_NUM-1, go to DUMP_DM with index = 0.

DUMP_DM:
- Same rule as DUMP_RF, using dm_raddr_o and dm_rdata_i, with dump_kind_o = 1.
- After loading index MEM_WORDS-1, go to DRAIN.

DRAIN:
- Wait for dump_ready_i on the last beat, then drop dump_valid_o.
- Next cycle: go to DONE.

DONE:
- done_o = 1. Stays in DONE until reset.

Handshake rules:
- A beat is transferred on any edge where dump_valid_o && dump_ready_i.
- Back-to-back beats are allowed: one per cycle when dump_ready_i stays high.
- dump_valid_o never drops without a transfer, except on reset.

Throughput and timing:
- Total beats = REG_NUM + MEM_WORDS. Each beat is presented exactly once.
- Minimum dump latency from FREEZE entry to done_o = REG_NUM + MEM_WORDS + 3 cycles with ready tied high.
- The index counter is 8 bits wide. Compare against the parameter minus 1; do not rely on wrap-around.

Decomposition:
- Shared package cpu_dbg_pkg:
  - state enum {RUN, FREEZE, DUMP_RF, DUMP_DM, DRAIN, DONE}.
  - DUMP_KIND_REG = 1'b0 and DUMP_KIND_MEM = 1'b1.
  - Debug-port width constants.
- One sub-module, dump_beat_reg: a valid/ready holding register with a load-enable output. It is reused by both dump states.

Test Plan:
1. PC sequence 0, 4, 8, 8, 8 with ready=1 -> cpu_stall_o rises the cycle after the third 8; halted_o = 1; cycles_o = 4.
2. PC increments forever, END_COUNT=600 -> FREEZE after 600 RUN cycles; halted_o = 0; cycles_o = 599.
3. RF[i] = i*3 and DM[j] = 100+j, ready=1 -> 44 beats, in order:
   - kind 0, index 0..31, data 0..93;
   - then kind 1, index 0..11, data 100..111;
   - done_o = 1 at FREEZE + 47 cycles.
4. ready toggling 1,0,0,1 on a beat -> data and index held through the low cycles; no duplicate or dropped beat (count still 44).
5. Halt and timeout in the same cycle (HALT_REPEAT=3, PC stuck from cycle 597) -> halted_o = 1.
6. rst_i asserted mid-DUMP_RF (index 10) -> next edge: dump_valid_o = 0, cpu_stall_o = 0, cycles_o = 0, state RUN.
